// File: rtl/eth_instream_pktzr.sv
// Packetizer that drains a show-ahead byte FIFO into a TX data FIFO.
// Each packet is a 4-byte sequence number, MSB first, followed by N payload
// bytes. A length word of N+4 follows the last byte.
// A packet starts once a full payload is waiting, or once a partial payload
// has sat idle for FLUSH_CYCLES cycles.
module eth_instream_pktzr #(
    parameter logic [15:0] PAYLOAD_LEN  = 16'h0400,
    parameter logic [23:0] FLUSH_CYCLES = 24'd125000
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [7:0]  instream_rddata,
    input  logic [11:0] instream_rcnt,
    input  logic        instream_fifoempty,
    output logic        instream_rden,
    input  logic        tx_data_fifo_full,
    input  logic        tx_len_fifo_full,
    output logic [7:0]  tx_data_fifo_data,
    output logic        tx_data_fifo_write,
    output logic [15:0] tx_len_fifo_data,
    output logic        tx_len_fifo_write,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        LEN  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] seq_reg, seq_next;
    logic [23:0] timer_reg, timer_next;
    logic [15:0] n_reg, n_next;
    // Byte index within the current phase: 0..3 in HDR, 0..N-1 in DATA.
    logic [15:0] cnt_reg, cnt_next;

    logic [15:0] rcnt_ext;
    logic        thresh_hit;
    logic        flush_hit;
    logic        start_pkt;

    assign rcnt_ext   = {4'b0000, instream_rcnt};
    assign thresh_hit = (rcnt_ext >= PAYLOAD_LEN);
    assign flush_hit  = (timer_reg == FLUSH_CYCLES) && !instream_fifoempty;
    assign start_pkt  = en && !tx_len_fifo_full && (thresh_hit || flush_hit);
    assign busy       = (state_reg != IDLE);

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            seq_reg   <= 32'h0000_0000;
            timer_reg <= 24'h00_0000;
            n_reg     <= 16'h0000;
            cnt_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            seq_reg   <= seq_next;
            timer_reg <= timer_next;
            n_reg     <= n_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and FIFO strobes. Strobes are combinational so that
    // a full flag stalls the same cycle it is seen, and no byte is lost.
    always_comb begin
        state_next         = state_reg;
        seq_next           = seq_reg;
        timer_next         = timer_reg;
        n_next             = n_reg;
        cnt_next           = cnt_reg;
        instream_rden      = 1'b0;
        tx_data_fifo_write = 1'b0;
        tx_data_fifo_data  = 8'h00;
        tx_len_fifo_write  = 1'b0;
        tx_len_fifo_data   = 16'h0000;
        case (state_reg)
            IDLE: begin
                if (start_pkt) begin
                    // The threshold path wins when both conditions hold.
                    // On the threshold path N is the full payload length.
                    state_next = HDR;
                    n_next     = thresh_hit ? PAYLOAD_LEN : rcnt_ext;
                    cnt_next   = 16'h0000;
                    timer_next = 24'h00_0000;
                end else if (instream_fifoempty) begin
                    timer_next = 24'h00_0000;
                end else if (!thresh_hit && (timer_reg != FLUSH_CYCLES)) begin
                    timer_next = timer_reg + 24'd1;
                end
            end
            HDR: begin
                if (!tx_data_fifo_full) begin
                    tx_data_fifo_write = 1'b1;
                    case (cnt_reg[1:0])
                        2'd0:    tx_data_fifo_data = seq_reg[31:24];
                        2'd1:    tx_data_fifo_data = seq_reg[23:16];
                        2'd2:    tx_data_fifo_data = seq_reg[15:8];
                        default: tx_data_fifo_data = seq_reg[7:0];
                    endcase
                    if (cnt_reg[1:0] == 2'd3) begin
                        state_next = DATA;
                        cnt_next   = 16'h0000;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            DATA: begin
                if (!tx_data_fifo_full && !instream_fifoempty) begin
                    instream_rden      = 1'b1;
                    tx_data_fifo_write = 1'b1;
                    tx_data_fifo_data  = instream_rddata;
                    if (cnt_reg == n_reg - 16'd1) begin
                        state_next = LEN;
                        cnt_next   = 16'h0000;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            default: begin
                // LEN: runs only after the last data byte has been written.
                if (!tx_len_fifo_full) begin
                    tx_len_fifo_write = 1'b1;
                    tx_len_fifo_data  = n_reg + 16'd4;
                    seq_next          = seq_reg + 32'd1;
                    state_next        = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_eth_instream_pktzr.sv
// Directed bench for eth_instream_pktzr (PAYLOAD_LEN=16, FLUSH_CYCLES=100).
// The instream FIFO is modelled as a queue. TX writes are collected into logs
// and compared against hand-built expected byte streams.
module tb_eth_instream_pktzr;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [7:0]  instream_rddata;
    logic [11:0] instream_rcnt;
    logic        instream_fifoempty;
    logic        instream_rden;
    logic        tx_data_fifo_full;
    logic        tx_len_fifo_full;
    logic [7:0]  tx_data_fifo_data;
    logic        tx_data_fifo_write;
    logic [15:0] tx_len_fifo_data;
    logic        tx_len_fifo_write;
    logic        busy;

    eth_instream_pktzr #(
        .PAYLOAD_LEN  (16'd16),
        .FLUSH_CYCLES (24'd100)
    ) dut (
        .sys_clk            (sys_clk),
        .reset_n            (reset_n),
        .en                 (en),
        .instream_rddata    (instream_rddata),
        .instream_rcnt      (instream_rcnt),
        .instream_fifoempty (instream_fifoempty),
        .instream_rden      (instream_rden),
        .tx_data_fifo_full  (tx_data_fifo_full),
        .tx_len_fifo_full   (tx_len_fifo_full),
        .tx_data_fifo_data  (tx_data_fifo_data),
        .tx_data_fifo_write (tx_data_fifo_write),
        .tx_len_fifo_data   (tx_len_fifo_data),
        .tx_len_fifo_write  (tx_len_fifo_write),
        .busy               (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  data_log[$];
    logic [15:0] len_log[$];
    int          lencnt_log[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  pkt_bytes[$];

    // Strobes captured mid-cycle: these are what the DUT acts on at the next edge.
    logic        s_rden, s_empty, s_wr, s_lenw;
    logic [7:0]  s_data;
    logic [15:0] s_len;

    // Sample DUT outputs on the falling edge.
    always @(negedge sys_clk) begin
        s_rden  = instream_rden;
        s_empty = instream_fifoempty;
        s_wr    = tx_data_fifo_write;
        s_data  = tx_data_fifo_data;
        s_lenw  = tx_len_fifo_write;
        s_len   = tx_len_fifo_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        instream_rcnt      = 12'(fifo_q.size());
        instream_fifoempty = (fifo_q.size() == 0);
        instream_rddata    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Advance one clock and apply what the DUT did at that edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (s_rden) begin
            chk("rden_not_empty", {31'd0, s_empty}, 32'd0);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (s_wr) begin
            data_log.push_back(s_data);
            $display("data write %02h", s_data);
        end
        if (s_lenw) begin
            len_log.push_back(s_len);
            lencnt_log.push_back(data_log.size());
            $display("length write %04h after %0d data bytes", s_len, data_log.size());
        end
        sync_fifo();
        #1;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 8'(i));
            pkt_bytes.push_back(base + 8'(i));
        end
        sync_fifo();
    endtask

    task automatic push_hdr(input logic [31:0] seq);
        exp_q.push_back(seq[31:24]);
        exp_q.push_back(seq[23:16]);
        exp_q.push_back(seq[15:8]);
        exp_q.push_back(seq[7:0]);
    endtask

    // Append the next n queued payload bytes to the expected stream.
    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pkt_bytes.pop_front());
    endtask

    task automatic wait_len(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (len_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, (len_log.size() >= n)}, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, data_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < data_log.size(); i++)
            chk(tag, {24'd0, data_log[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic clear_logs();
        data_log.delete();
        len_log.delete();
        lencnt_log.delete();
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0;
        tx_data_fifo_full = 1'b0; tx_len_fifo_full = 1'b0;
        sync_fifo();
        tick(); tick();
        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rden", {31'd0, instream_rden}, 32'd0);
        chk("rst_wr", {31'd0, tx_data_fifo_write}, 32'd0);
        chk("rst_lenw", {31'd0, tx_len_fifo_write}, 32'd0);
        chk("rst_data", {24'd0, tx_data_fifo_data}, 32'd0);
        chk("rst_len", {16'd0, tx_len_fifo_data}, 32'd0);
        reset_n = 1'b1; en = 1'b1;
        tick();

        // Full packet: 16 bytes 00..0F, sequence 0.
        push_bytes(16, 8'h00);
        push_hdr(32'd0); push_payload(16);
        wait_len("full_timeout", 1, 200);
        check_stream("full_stream");
        chk("full_len", {16'd0, len_log[0]}, 32'h14);
        chk("full_len_after_last", lencnt_log[0], 20);
        tick();
        clear_logs();

        // Flush of 5 bytes after exactly 100 idle cycles, sequence 1.
        push_bytes(5, 8'hA0);
        for (int i = 0; i < 100; i++) tick();
        chk("flush_not_early", {31'd0, busy}, 32'd0);
        chk("flush_no_data_early", data_log.size(), 0);
        tick();
        chk("flush_start", {31'd0, busy}, 32'd1);
        push_hdr(32'd1); push_payload(5);
        wait_len("flush_timeout", 1, 200);
        check_stream("flush_stream");
        chk("flush_len", {16'd0, len_log[0]}, 32'h9);
        tick();
        clear_logs();

        // Random backpressure over two back-to-back packets, sequences 2,3.
        push_bytes(32, 8'h40);
        push_hdr(32'd2); push_payload(16);
        push_hdr(32'd3); push_payload(16);
        for (int k = 0; k < 2000 && len_log.size() < 2; k++) begin
            tx_data_fifo_full = ($urandom_range(0, 1) == 1);
            tx_len_fifo_full  = ($urandom_range(0, 3) == 0);
            tick();
        end
        tx_data_fifo_full = 1'b0; tx_len_fifo_full = 1'b0;
        chk("stall_done", len_log.size(), 2);
        check_stream("stall_stream");
        if (len_log.size() == 2) begin
            chk("stall_len0", {16'd0, len_log[0]}, 32'h14);
            chk("stall_len1", {16'd0, len_log[1]}, 32'h14);
            chk("stall_len0_after_last", lencnt_log[0], 20);
            chk("stall_len1_after_last", lencnt_log[1], 40);
        end
        tick();
        clear_logs();

        // Sequence wrap: load FFFFFFFF through the next-state value.
        force dut.seq_next = 32'hFFFF_FFFF;
        tick();
        release dut.seq_next;
        tick();
        push_bytes(32, 8'h80);
        push_hdr(32'hFFFF_FFFF); push_payload(16);
        push_hdr(32'h0000_0000); push_payload(16);
        wait_len("wrap_timeout", 2, 300);
        check_stream("wrap_stream");
        tick();
        clear_logs();

        // en dropped mid-DATA: packet finishes, nothing new until en returns.
        push_bytes(32, 8'hC0);
        push_hdr(32'd1); push_payload(16);
        for (int k = 0; k < 100 && data_log.size() < 10; k++) tick();
        en = 1'b0;
        wait_len("en_timeout", 1, 200);
        chk("en_len", {16'd0, len_log[0]}, 32'h14);
        for (int i = 0; i < 50; i++) tick();
        chk("en_hold_busy", {31'd0, busy}, 32'd0);
        chk("en_hold_nolen", len_log.size(), 1);
        chk("en_hold_rcnt", {20'd0, instream_rcnt}, 32'd16);
        en = 1'b1;
        push_hdr(32'd2); push_payload(16);
        wait_len("en_resume_timeout", 2, 200);
        check_stream("en_stream");
        tick();
        clear_logs();

        // Reset after 10 data bytes: partial packet dropped, sequence restarts.
        push_bytes(16, 8'h10);
        for (int k = 0; k < 100 && data_log.size() < 14; k++) tick();
        reset_n = 1'b0;
        fifo_q.delete(); pkt_bytes.delete();
        sync_fifo();
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rden", {31'd0, instream_rden}, 32'd0);
        chk("mid_rst_wr", {31'd0, tx_data_fifo_write}, 32'd0);
        chk("mid_rst_lenw", {31'd0, tx_len_fifo_write}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data_fifo_data}, 32'd0);
        chk("mid_rst_len", {16'd0, tx_len_fifo_data}, 32'd0);
        tick(); tick();
        chk("mid_rst_no_len", len_log.size(), 0);
        reset_n = 1'b1;
        tick();
        clear_logs();
        push_bytes(16, 8'h30);
        push_hdr(32'd0); push_payload(16);
        wait_len("post_rst_timeout", 1, 200);
        check_stream("post_rst_stream");
        if (len_log.size() != 0) chk("post_rst_len", {16'd0, len_log[0]}, 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
